// File: rtl/counter_arb_pkg.sv
// Shared types and default constants for the counter arbiter.
package counter_arb_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      REINIT = 2'd1,
      SETTLE = 2'd2
   } arb_state_t;

   localparam int DEF_AMT_W   = 2;
   localparam int DEF_VAL_W   = 4;
   localparam int DEF_MAX_VAL = 10;
   localparam int STATS_W     = 16;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any
);

   logic [PW-1:0] j_idx;

   // Scan from farthest to nearest offset so the nearest hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j_idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j_idx = PW'((int'(ptr) + k) % N);
         if (req[j_idx]) begin
            grant        = '0;
            grant[j_idx] = 1'b1;
            grant_idx    = j_idx;
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrates NUM_REQ requesters onto a shared modulo up/down counter, with reinit sequencing.
// Optional COUNTER_ARB_STATS_EN adds stall_cycles / grant_cycles counters.
module counter_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int AMT_W   = DEF_AMT_W,
   parameter int VAL_W   = DEF_VAL_W,
   parameter int MAX_VAL = DEF_MAX_VAL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_dir,
   input  logic [NUM_REQ*AMT_W-1:0] req_amt,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     reinit_req,
   input  logic [VAL_W-1:0]         reinit_value,
   output logic                     reinit_ack,
   input  logic [VAL_W-1:0]         cnt_value,
   output logic [AMT_W-1:0]         cnt_incr,
   output logic                     cnt_incr_valid,
   output logic [AMT_W-1:0]         cnt_decr,
   output logic                     cnt_decr_valid,
   output logic                     cnt_reinit,
   output logic [VAL_W-1:0]         cnt_initial_value,
   output logic                     at_zero,
   output logic                     at_max
`ifdef COUNTER_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0]       stall_cycles,
   output logic [STATS_W-1:0]       grant_cycles
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         state_reg, state_next;
   logic [PW-1:0]      inc_ptr_reg, inc_ptr_next;
   logic [PW-1:0]      dec_ptr_reg, dec_ptr_next;
   logic [NUM_REQ-1:0] inc_cand, dec_cand;
   logic [NUM_REQ-1:0] inc_grant, dec_grant;
   logic [PW-1:0]      inc_idx, dec_idx;
   logic               inc_any, dec_any;
   logic [AMT_W-1:0]   amt_arr [NUM_REQ];
   logic               at_zero_reg, at_max_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_split
         assign amt_arr[gi]  = req_amt[gi*AMT_W +: AMT_W];
         assign inc_cand[gi] = req_valid[gi] & req_dir[gi];
         assign dec_cand[gi] = req_valid[gi] & ~req_dir[gi];
      end
   endgenerate

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_inc_pick (
      .req(inc_cand), .ptr(inc_ptr_reg),
      .grant(inc_grant), .grant_idx(inc_idx), .any(inc_any)
   );

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_dec_pick (
      .req(dec_cand), .ptr(dec_ptr_reg),
      .grant(dec_grant), .grant_idx(dec_idx), .any(dec_any)
   );

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
      return (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= RUN;
         inc_ptr_reg <= '0;
         dec_ptr_reg <= '0;
         at_zero_reg <= 1'b0;
         at_max_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         inc_ptr_reg <= inc_ptr_next;
         dec_ptr_reg <= dec_ptr_next;
         at_zero_reg <= (cnt_value == '0);
         at_max_reg  <= (cnt_value == VAL_W'(MAX_VAL));
      end
   end

   // Outputs are forced idle while rst is high so the counter sees nothing spurious.
   always_comb begin
      state_next        = state_reg;
      inc_ptr_next      = inc_ptr_reg;
      dec_ptr_next      = dec_ptr_reg;
      req_ready         = '0;
      cnt_incr          = '0;
      cnt_incr_valid    = 1'b0;
      cnt_decr          = '0;
      cnt_decr_valid    = 1'b0;
      cnt_reinit        = 1'b0;
      cnt_initial_value = '0;
      reinit_ack        = 1'b0;
      if (!rst) begin
         case (state_reg)
            RUN: begin
               if (reinit_req) begin
                  state_next = REINIT;
               end else begin
                  req_ready = inc_grant | dec_grant;
                  if (inc_any) begin
                     cnt_incr       = amt_arr[inc_idx];
                     cnt_incr_valid = 1'b1;
                     inc_ptr_next   = ptr_after(inc_idx);
                  end
                  if (dec_any) begin
                     cnt_decr       = amt_arr[dec_idx];
                     cnt_decr_valid = 1'b1;
                     dec_ptr_next   = ptr_after(dec_idx);
                  end
               end
            end
            REINIT: begin
               cnt_reinit        = 1'b1;
               cnt_initial_value = reinit_value;
               reinit_ack        = 1'b1;
               state_next        = SETTLE;
            end
            SETTLE: begin
               state_next = reinit_req ? REINIT : RUN;
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign at_zero = at_zero_reg;
   assign at_max  = at_max_reg;

`ifdef COUNTER_ARB_STATS_EN
   logic [STATS_W-1:0] stall_cycles_reg, grant_cycles_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_reg <= '0;
         grant_cycles_reg <= '0;
      end else begin
         if (|(req_valid & ~req_ready) && (stall_cycles_reg != '1))
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
         if (|req_ready && (grant_cycles_reg != '1))
            grant_cycles_reg <= grant_cycles_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign grant_cycles = grant_cycles_reg;
`endif

endmodule
